dac_2comp_out: RTL and testbench

Output-side counterpart of the ADC input converter. Takes two signed two's-complement channels from the processing core and saturates them to the DAC width. Applies an optional per-cycle slew limit, then converts to the DAC's inverted offset code: code = {y[MSB], ~y[MSB-1:0]}, the exact inverse of the ADC mapping. Sits between the lock/feedback datapath and the DAC pins. Also reports sticky saturation status.

---
 rtl/dac_2comp_out.sv | 139 +++++++++++++
 tb/tb_dac_2comp_out.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_2comp_out.sv
// Two-channel DAC output stage: saturate core samples to the DAC range, slew-limit,
// and emit the inverted offset code, with sticky saturation flags and event counters.
module dac_2comp_out #(
    parameter int IN_BITS  = 16,
    parameter int BITS     = 14,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  dac_a_i,
    input  logic [IN_BITS-1:0]  dac_b_i,
    input  logic [BITS-2:0]     slew_max_i,
    input  logic                clr_flags,
    output logic [BITS-1:0]     dac_a_o,
    output logic [BITS-1:0]     dac_b_o,
    output logic                out_valid,
    output logic                sat_a,
    output logic                sat_b,
    output logic [CNT_BITS-1:0] sat_cnt_a,
    output logic [CNT_BITS-1:0] sat_cnt_b
);

    localparam logic signed [IN_BITS-1:0] IN_MAX = {{(IN_BITS-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [IN_BITS-1:0] IN_MIN = {{(IN_BITS-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    localparam logic signed [BITS-1:0]    Y_MAX  = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0]    Y_MIN  = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0]           MIDSCALE = {1'b0, {(BITS-1){1'b1}}};

    logic signed [BITS-1:0] tgt_a, tgt_b;
    logic signed [BITS-1:0] y_a, y_b;
    logic                   vld_s1, vld_s2;
    logic                   ev_a, ev_b;

    function automatic logic ovf(input logic signed [IN_BITS-1:0] x);
        return (x > IN_MAX) || (x < IN_MIN);
    endfunction

    function automatic logic signed [BITS-1:0] clamp_in(input logic signed [IN_BITS-1:0] x);
        if (x > IN_MAX)
            return Y_MAX;
        else if (x < IN_MIN)
            return Y_MIN;
        else
            return x[BITS-1:0];
    endfunction

    // Difference is formed one bit wider so a full-scale swing cannot wrap.
    function automatic logic signed [BITS-1:0] slew_step(
        input logic signed [BITS-1:0] tgt,
        input logic signed [BITS-1:0] y,
        input logic [BITS-2:0]        lim
    );
        logic signed [BITS:0] d;
        logic signed [BITS:0] s;
        logic signed [BITS:0] ye;
        logic signed [BITS:0] res;
        ye = {y[BITS-1], y};
        d  = {tgt[BITS-1], tgt} - ye;
        s  = {2'b00, lim};
        if (lim == '0)
            res = {tgt[BITS-1], tgt};
        else if (d > s)
            res = ye + s;
        else if (d < -s)
            res = ye - s;
        else
            res = {tgt[BITS-1], tgt};
        return res[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] to_code(input logic signed [BITS-1:0] y);
        return {y[BITS-1], ~y[BITS-2:0]};
    endfunction

    // A clear coinciding with an event leaves the count at one.
    function automatic logic [CNT_BITS-1:0] cnt_next(
        input logic [CNT_BITS-1:0] c,
        input logic                ev,
        input logic                clr
    );
        if (clr)
            return {{(CNT_BITS-1){1'b0}}, ev};
        else if (ev && (c != '1))
            return c + CNT_BITS'(1);
        else
            return c;
    endfunction

    assign ev_a = en && in_valid && ovf(dac_a_i);
    assign ev_b = en && in_valid && ovf(dac_b_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_a     <= '0;
            tgt_b     <= '0;
            y_a       <= '0;
            y_b       <= '0;
            dac_a_o   <= MIDSCALE;
            dac_b_o   <= MIDSCALE;
            vld_s1    <= 1'b0;
            vld_s2    <= 1'b0;
            out_valid <= 1'b0;
            sat_a     <= 1'b0;
            sat_b     <= 1'b0;
            sat_cnt_a <= '0;
            sat_cnt_b <= '0;
        end else begin
            if (!en) begin
                tgt_a <= '0;
                tgt_b <= '0;
                y_a   <= '0;
                y_b   <= '0;
            end else begin
                if (in_valid) begin
                    tgt_a <= clamp_in(dac_a_i);
                    tgt_b <= clamp_in(dac_b_i);
                end
                y_a <= slew_step(tgt_a, y_a, slew_max_i);
                y_b <= slew_step(tgt_b, y_b, slew_max_i);
            end

            dac_a_o <= to_code(y_a);
            dac_b_o <= to_code(y_b);

            // Valid travels alongside the target/slew/output registers.
            vld_s1    <= en && in_valid;
            vld_s2    <= en && vld_s1;
            out_valid <= en && vld_s2;

            sat_a     <= ev_a || (sat_a && !clr_flags);
            sat_b     <= ev_b || (sat_b && !clr_flags);
            sat_cnt_a <= cnt_next(sat_cnt_a, ev_a, clr_flags);
            sat_cnt_b <= cnt_next(sat_cnt_b, ev_b, clr_flags);
        end
    end

endmodule

// File: tb/tb_dac_2comp_out.sv
// Scoreboard bench for dac_2comp_out: an integer reference model predicts every cycle's
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_dac_2comp_out;

    localparam int IN_BITS  = 16;
    localparam int BITS     = 14;
    localparam int CNT_BITS = 8;
    localparam int YMAX     = 8191;
    localparam int YMIN     = -8192;
    localparam int CMAX     = 255;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                in_valid = 1'b0;
    logic [IN_BITS-1:0]  dac_a_i = '0;
    logic [IN_BITS-1:0]  dac_b_i = '0;
    logic [BITS-2:0]     slew_max_i = '0;
    logic                clr_flags = 1'b0;
    logic [BITS-1:0]     dac_a_o, dac_b_o;
    logic                out_valid, sat_a, sat_b;
    logic [CNT_BITS-1:0] sat_cnt_a, sat_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    dac_2comp_out #(.IN_BITS(IN_BITS), .BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .dac_a_i(dac_a_i), .dac_b_i(dac_b_i), .slew_max_i(slew_max_i),
        .clr_flags(clr_flags), .dac_a_o(dac_a_o), .dac_b_o(dac_b_o),
        .out_valid(out_valid), .sat_a(sat_a), .sat_b(sat_b),
        .sat_cnt_a(sat_cnt_a), .sat_cnt_b(sat_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit ov;
        int ca;
        int cb;
        bit sa;
        bit sb;
        int na;
        int nb;
    } exp_t;

    exp_t q[$];
    exp_t px, mx;

    int  m_tgt_a, m_tgt_b, m_y_a, m_y_b;
    bit  m_v1, m_v2, m_ov;
    bit  m_sa, m_sb;
    int  m_na, m_nb;
    int  ia, ib, sl, ca, cb;
    bit  e, iv, clr, eva, evb;

    function automatic int clampi(input int x);
        if (x > YMAX) return YMAX;
        if (x < YMIN) return YMIN;
        return x;
    endfunction

    function automatic int stepi(input int tgt, input int y, input int s);
        int d;
        if (s == 0) return tgt;
        d = tgt - y;
        if (d > s) return y + s;
        if (d < -s) return y - s;
        return tgt;
    endfunction

    function automatic int cnti(input int c, input bit ev, input bit cl);
        if (cl) return ev ? 1 : 0;
        if (ev && c < CMAX) return c + 1;
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tgt_a = 0; m_tgt_b = 0; m_y_a = 0; m_y_b = 0;
            m_v1 = 0; m_v2 = 0; m_ov = 0;
            m_sa = 0; m_sb = 0; m_na = 0; m_nb = 0;
            q.delete();
        end else begin
            e   = en;
            iv  = in_valid;
            clr = clr_flags;
            ia  = int'($signed(dac_a_i));
            ib  = int'($signed(dac_b_i));
            sl  = int'(slew_max_i);
            // The code is a reflection about midscale: y=+max -> 0, y=min -> full code.
            ca = YMAX - m_y_a;
            cb = YMAX - m_y_b;
            eva = e && iv && (ia > YMAX || ia < YMIN);
            evb = e && iv && (ib > YMAX || ib < YMIN);
            m_y_a = e ? stepi(m_tgt_a, m_y_a, sl) : 0;
            m_y_b = e ? stepi(m_tgt_b, m_y_b, sl) : 0;
            if (!e) begin
                m_tgt_a = 0; m_tgt_b = 0;
            end else if (iv) begin
                m_tgt_a = clampi(ia); m_tgt_b = clampi(ib);
            end
            m_ov = e && m_v2;
            m_v2 = e && m_v1;
            m_v1 = e && iv;
            m_sa = eva || (m_sa && !clr);
            m_sb = evb || (m_sb && !clr);
            m_na = cnti(m_na, eva, clr);
            m_nb = cnti(m_nb, evb, clr);
            px.ov = m_ov; px.ca = ca; px.cb = cb;
            px.sa = m_sa; px.sb = m_sb; px.na = m_na; px.nb = m_nb;
            q.push_back(px);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && q.size() > 0) begin
            mx = q.pop_front();
            check("out_valid", int'(out_valid), int'(mx.ov));
            check("dac_a_o",   int'(dac_a_o),   mx.ca);
            check("dac_b_o",   int'(dac_b_o),   mx.cb);
            check("sat_a",     int'(sat_a),     int'(mx.sa));
            check("sat_b",     int'(sat_b),     int'(mx.sb));
            check("sat_cnt_a", int'(sat_cnt_a), mx.na);
            check("sat_cnt_b", int'(sat_cnt_b), mx.nb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit de, input bit dv, input int a, input int b,
                         input int s, input bit dc);
        @(negedge clk);
        en         = de;
        in_valid   = dv;
        dac_a_i    = a[IN_BITS-1:0];
        dac_b_i    = b[IN_BITS-1:0];
        slew_max_i = s[BITS-2:0];
        clr_flags  = dc;
    endtask

    task automatic idle(input bit de, input int s, input int n);
        for (int i = 0; i < n; i++) drive(de, 1'b0, 0, 0, s, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dac_a"},   int'(dac_a_o),   'h1FFF);
        check({tag, "_dac_b"},   int'(dac_b_o),   'h1FFF);
        check({tag, "_valid"},   int'(out_valid), 0);
        check({tag, "_sat_a"},   int'(sat_a),     0);
        check({tag, "_sat_b"},   int'(sat_b),     0);
        check({tag, "_cnt_a"},   int'(sat_cnt_a), 0);
        check({tag, "_cnt_b"},   int'(sat_cnt_b), 0);
    endtask

    initial begin
        int a, b, s;
        bit de, dv, dc;

        // Reset held
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(1'b0, 0, 3);

        // Mapping and latency, unlimited slew
        drive(1'b1, 1'b1, 'h0000, 'h0000, 0, 1'b0); idle(1'b1, 0, 4);
        drive(1'b1, 1'b1, 'h1FFF, 'hFFFF, 0, 1'b0); idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 'hE000, 'h0001, 0, 1'b0); idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 'h0123, 'hFFFF, 0, 1'b0); idle(1'b1, 0, 3);

        // Saturation, sticky flags, counters
        drive(1'b1, 1'b1, 'h7FFF, 'h0000, 0, 1'b0); idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 'h8000, 'h2000, 0, 1'b0); idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 'h4000, 'h0000, 0, 1'b1); idle(1'b1, 0, 3);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);           idle(1'b1, 0, 2);

        // Slew ramp up to 1000, then down through zero to -50
        drive(1'b1, 1'b1, 0, 0, 0, 1'b0);            idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 1000, -1000, 100, 1'b0);   idle(1'b1, 100, 13);
        drive(1'b1, 1'b1, -50, 50, 100, 1'b0);       idle(1'b1, 100, 14);

        // Full-scale step with the widest slew limit
        drive(1'b1, 1'b1, 'hE000, 'h1FFF, 0, 1'b0);  idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 'h1FFF, 'hE000, 8191, 1'b0); idle(1'b1, 8191, 4);

        // Disable in the middle of a ramp, then re-enable and ramp from zero
        drive(1'b1, 1'b1, 'h7FFF, 0, 0, 1'b0);       idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 0, 0, 0, 1'b0);            idle(1'b1, 0, 3);
        drive(1'b1, 1'b1, 1000, 700, 100, 1'b0);     idle(1'b1, 100, 4);
        drive(1'b0, 1'b1, 'h7FFF, 'h7FFF, 100, 1'b0); idle(1'b0, 100, 3);
        drive(1'b1, 1'b1, 600, -600, 250, 1'b0);     idle(1'b1, 250, 5);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            de = ($urandom_range(0, 9) != 0);
            dv = ($urandom_range(0, 2) != 0);
            dc = ($urandom_range(0, 19) == 0);
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 16383)) - 8192;
            b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 16383)) - 8192;
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = int'($urandom_range(1, 64));
                2:       s = int'($urandom_range(1, 2000));
                default: s = int'($urandom_range(1, 8191));
            endcase
            drive(de, dv, a, b, s, dc);
        end

        // Counter saturation at its top value
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < CMAX + 5; i++) drive(1'b1, 1'b1, 'h7FFF, 'h8000, 0, 1'b0);
        idle(1'b1, 0, 3);

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        check_reset_values("rst_held");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
